// File: rtl/sdf_stage_ctrl_pkg.sv
// Shared constants and types for the 32-point SDF FFT stage controllers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sdf_stage_ctrl_pkg;

  localparam int FFT_N    = 32;
  localparam int FFT_LOGN = $clog2(FFT_N);
  localparam int FFT_DW   = 19;
  localparam int FFT_TW   = 9;

  // Q1.7 unity: +1.0 = 128
  localparam logic signed [FFT_TW-1:0] Q17_ONE = 9'sd128;

  // Stage sequencer states, encoding visible on the state output
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRIME = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  // One twiddle factor, real and imaginary parts in Q1.7
  typedef struct packed {
    logic signed [FFT_TW-1:0] re;
    logic signed [FFT_TW-1:0] im;
  } tw_t;

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Sample/control bundle between an SDF stage controller and its neighbours.
// Latency: none (wires only).
// Backpressure: ready_o from the controller gates valid_i acceptance.
interface sdf_stage_ctrl_if
  import sdf_stage_ctrl_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int TW = FFT_TW
);

  logic                 valid_i;
  logic                 last_i;
  logic                 ready_o;
  logic signed [DW-1:0] data_in_r;
  logic signed [DW-1:0] data_in_i;
  logic signed [DW-1:0] data_out_r;
  logic signed [DW-1:0] data_out_i;
  logic [1:0]           state;
  logic                 shift_en;
  logic                 bf_mode;
  logic signed [TW-1:0] WN_r;
  logic signed [TW-1:0] WN_i;
  logic                 valid_o;
  logic                 err_o;

  // Upstream side: supplies samples, observes the stage controls
  modport master (
    output valid_i, last_i, data_in_r, data_in_i,
    input  ready_o, data_out_r, data_out_i, state, shift_en, bf_mode,
           WN_r, WN_i, valid_o, err_o
  );

  // Controller side
  modport slave (
    input  valid_i, last_i, data_in_r, data_in_i,
    output ready_o, data_out_r, data_out_i, state, shift_en, bf_mode,
           WN_r, WN_i, valid_o, err_o
  );

endinterface

// File: rtl/sdf_stage_ctrl_twiddle_rom.sv
// Twiddle lookup W_32^k = round(128cos(2pi k/32)) - j*round(128sin(2pi k/32)), k = 0..15.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module sdf_stage_ctrl_twiddle_rom
  import sdf_stage_ctrl_pkg::*;
(
  input  logic [FFT_LOGN-2:0] k,
  output tw_t                 w
);

  // Constant table, rounded half away from zero
  always_comb begin
    w.re = Q17_ONE;
    w.im = '0;
    case (k)
      4'd0:  begin w.re =  9'sd128; w.im =  9'sd0;   end
      4'd1:  begin w.re =  9'sd126; w.im = -9'sd25;  end
      4'd2:  begin w.re =  9'sd118; w.im = -9'sd49;  end
      4'd3:  begin w.re =  9'sd106; w.im = -9'sd71;  end
      4'd4:  begin w.re =  9'sd91;  w.im = -9'sd91;  end
      4'd5:  begin w.re =  9'sd71;  w.im = -9'sd106; end
      4'd6:  begin w.re =  9'sd49;  w.im = -9'sd118; end
      4'd7:  begin w.re =  9'sd25;  w.im = -9'sd126; end
      4'd8:  begin w.re =  9'sd0;   w.im = -9'sd128; end
      4'd9:  begin w.re = -9'sd25;  w.im = -9'sd126; end
      4'd10: begin w.re = -9'sd49;  w.im = -9'sd118; end
      4'd11: begin w.re = -9'sd71;  w.im = -9'sd106; end
      4'd12: begin w.re = -9'sd91;  w.im = -9'sd91;  end
      4'd13: begin w.re = -9'sd106; w.im = -9'sd71;  end
      4'd14: begin w.re = -9'sd118; w.im = -9'sd49;  end
      4'd15: begin w.re = -9'sd126; w.im = -9'sd25;  end
      default: begin w.re = Q17_ONE; w.im = '0; end
    endcase
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF DIF stage: butterfly mode, delay-line shift, twiddle, valid.
// Latency: 1 cycle from accepted sample to registered data/controls; flush steps likewise trail the FLUSH state by 1.
// Backpressure: ready_o is low for the D cycles of FLUSH; valid_i is ignored while low.
module sdf_stage_ctrl
  import sdf_stage_ctrl_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int STAGE = 0,
  parameter int DW    = FFT_DW,
  parameter int TW    = FFT_TW
)(
  input  logic         clk,
  input  logic         rst,
  sdf_stage_ctrl_if.slave bus
);

  localparam int LOGN = $clog2(N);
  localparam int D    = N >> (STAGE + 1);
  localparam int CW   = $clog2(2 * D);   // block counter width, at least 1
  localparam int KW   = LOGN - 1;        // twiddle index width (k < N/2)

  localparam logic [CW-1:0] D_M1     = CW'(D - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * D - 1);
  localparam logic signed [TW-1:0] W_ONE = TW'(Q17_ONE);

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic          accept;
  logic          fill;
  logic          blk_end;
  logic [KW-1:0] k_idx;
  logic [KW-1:0] k_sel;
  tw_t           w_rom;

  assign bus.state   = st;
  assign bus.ready_o = (st != ST_FLUSH);
  assign accept      = bus.valid_i & (st != ST_FLUSH);
  // 2D is a power of two, so the first half of the block is cnt MSB clear
  assign fill        = ~cnt[CW-1];
  assign blk_end     = (st == ST_RUN) && (cnt == LAST_CNT);

  // Twiddle exponent: fill position or flush step, scaled by the stage stride; 0 for butterfly
  always_comb begin
    k_idx = '0;
    if (st == ST_FLUSH)
      k_idx = KW'(fcnt);
    else if (fill)
      k_idx = KW'(cnt & D_M1);
  end

  assign k_sel = k_idx << STAGE;

  sdf_stage_ctrl_twiddle_rom u_twiddle_rom (
    .k (k_sel),
    .w (w_rom)
  );

  // FSM with the in-block sample counter and the flush step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      fcnt <= '0;
    end else if (st == ST_FLUSH) begin
      if (fcnt == D_M1) begin
        st   <= ST_IDLE;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else if (accept) begin
      case (st)
        ST_IDLE, ST_PRIME: begin
          // Priming ends once the first D samples sit in the delay line
          st  <= (cnt == D_M1) ? ST_RUN : ST_PRIME;
          cnt <= cnt + 1'b1;
        end
        default: begin
          if (bus.last_i && blk_end) begin
            st  <= ST_FLUSH;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Output registers: sample and its controls, or one flush step of zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out_r <= {DW{1'b0}};
      bus.data_out_i <= {DW{1'b0}};
      bus.shift_en   <= 1'b0;
      bus.bf_mode    <= 1'b0;
      bus.valid_o    <= 1'b0;
      bus.err_o      <= 1'b0;
      bus.WN_r       <= W_ONE;
      bus.WN_i       <= '0;
    end else begin
      bus.err_o <= 1'b0;
      if (st == ST_FLUSH) begin
        bus.data_out_r <= {DW{1'b0}};
        bus.data_out_i <= {DW{1'b0}};
        bus.shift_en   <= 1'b1;
        bus.bf_mode    <= 1'b0;
        bus.valid_o    <= 1'b1;
        bus.WN_r       <= TW'(w_rom.re);
        bus.WN_i       <= TW'(w_rom.im);
      end else if (accept) begin
        bus.data_out_r <= bus.data_in_r;
        bus.data_out_i <= bus.data_in_i;
        bus.shift_en   <= 1'b1;
        bus.bf_mode    <= ~fill;
        bus.valid_o    <= (st == ST_RUN);
        bus.WN_r       <= TW'(w_rom.re);
        bus.WN_i       <= TW'(w_rom.im);
        // A misplaced last is flagged and otherwise ignored
        bus.err_o      <= bus.last_i & ~blk_end;
      end else begin
        bus.shift_en   <= 1'b0;
        bus.valid_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: STAGE=0 (D=16) directed bursts, STAGE=4 (D=1) random traffic.
// Both are compared every cycle against a sample-count model of the stage schedule.
module tb_sdf_stage_ctrl;
  import sdf_stage_ctrl_pkg::*;

  localparam logic [1:0] M_IDLE = 2'd0, M_PRIME = 2'd1, M_RUN = 2'd2, M_FLUSH = 2'd3;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdf_stage_ctrl_if #(.DW(19), .TW(9)) ifa ();
  sdf_stage_ctrl_if #(.DW(19), .TW(9)) ifb ();

  sdf_stage_ctrl #(.N(32), .STAGE(0), .DW(19), .TW(9)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sdf_stage_ctrl #(.N(32), .STAGE(4), .DW(19), .TW(9)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic               v  [2];
  logic               l  [2];
  logic signed [18:0] xr [2];
  logic signed [18:0] xi [2];

  assign ifa.valid_i = v[0];  assign ifa.last_i = l[0];
  assign ifa.data_in_r = xr[0]; assign ifa.data_in_i = xi[0];
  assign ifb.valid_i = v[1];  assign ifb.last_i = l[1];
  assign ifb.data_in_r = xr[1]; assign ifb.data_in_i = xi[1];

  typedef struct {
    logic [1:0] st;
    logic rdy, sh, bf, vo, er;
    logic signed [18:0] dr, di;
    logic signed [8:0]  wr, wi;
  } obs_t;

  obs_t ex [2];
  int   s  [2];                  // samples accepted since the burst began
  int   fl [2];                  // flush outputs still to come
  int   dd [2]  = '{16, 1};
  int   stg [2] = '{0, 4};
  int   total = 0;
  int   bad   = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int twr(input int k);
    return rnd(128.0 * $cos(2.0 * PI * k / 32.0));
  endfunction

  function automatic int twi(input int k);
    return -rnd(128.0 * $sin(2.0 * PI * k / 32.0));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s[i] = 0; fl[i] = 0;
      ex[i].st = M_IDLE; ex[i].rdy = 1'b1; ex[i].sh = 1'b0; ex[i].bf = 1'b0;
      ex[i].vo = 1'b0; ex[i].er = 1'b0; ex[i].dr = '0; ex[i].di = '0;
      ex[i].wr = 9'sd128; ex[i].wi = '0;
    end
  endtask

  // Expected outputs after the coming edge, from the inputs now applied
  task automatic model_step(input int i);
    int d, p, k;
    d = dd[i];
    ex[i].er = 1'b0;
    if (fl[i] > 0) begin
      k = (d - fl[i]) << stg[i];
      fl[i] = fl[i] - 1;
      ex[i].sh = 1'b1; ex[i].bf = 1'b0; ex[i].vo = 1'b1;
      ex[i].dr = '0; ex[i].di = '0;
      ex[i].wr = 9'(twr(k)); ex[i].wi = 9'(twi(k));
      ex[i].st  = (fl[i] > 0) ? M_FLUSH : M_IDLE;
      ex[i].rdy = (fl[i] == 0);
    end else if (v[i]) begin
      p = s[i] % (2 * d);
      k = (p >= d) ? 0 : ((p % d) << stg[i]);
      ex[i].sh = 1'b1; ex[i].bf = (p >= d); ex[i].vo = (s[i] >= d);
      ex[i].dr = xr[i]; ex[i].di = xi[i];
      ex[i].wr = 9'(twr(k)); ex[i].wi = 9'(twi(k));
      if (l[i] && s[i] >= d && p == 2 * d - 1) begin
        fl[i] = d; s[i] = 0; ex[i].st = M_FLUSH; ex[i].rdy = 1'b0;
      end else begin
        ex[i].er = l[i];
        s[i] = s[i] + 1;
        ex[i].st = (s[i] >= d) ? M_RUN : M_PRIME;
      end
    end else begin
      ex[i].sh = 1'b0; ex[i].vo = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic check_all(input int i);
    obs_t o;
    string nm;
    if (i == 0) begin
      nm = "stg0";
      o.st = ifa.state; o.rdy = ifa.ready_o; o.sh = ifa.shift_en; o.bf = ifa.bf_mode;
      o.vo = ifa.valid_o; o.er = ifa.err_o; o.dr = ifa.data_out_r; o.di = ifa.data_out_i;
      o.wr = ifa.WN_r; o.wi = ifa.WN_i;
    end else begin
      nm = "stg4";
      o.st = ifb.state; o.rdy = ifb.ready_o; o.sh = ifb.shift_en; o.bf = ifb.bf_mode;
      o.vo = ifb.valid_o; o.er = ifb.err_o; o.dr = ifb.data_out_r; o.di = ifb.data_out_i;
      o.wr = ifb.WN_r; o.wi = ifb.WN_i;
    end
    chk({nm, ".state"},    32'(o.st),  32'(ex[i].st));
    chk({nm, ".ready"},    32'(o.rdy), 32'(ex[i].rdy));
    chk({nm, ".shift_en"}, 32'(o.sh),  32'(ex[i].sh));
    chk({nm, ".bf_mode"},  32'(o.bf),  32'(ex[i].bf));
    chk({nm, ".valid_o"},  32'(o.vo),  32'(ex[i].vo));
    chk({nm, ".err_o"},    32'(o.er),  32'(ex[i].er));
    chk({nm, ".data_r"},   32'(o.dr),  32'(ex[i].dr));
    chk({nm, ".data_i"},   32'(o.di),  32'(ex[i].di));
    chk({nm, ".WN_r"},     32'(o.wr),  32'(ex[i].wr));
    chk({nm, ".WN_i"},     32'(o.wi),  32'(ex[i].wi));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
    v[1]  = ($urandom_range(0, 3) != 0);
    l[1]  = ($urandom_range(0, 5) == 0);
    xr[1] = 19'($urandom);
    xi[1] = 19'($urandom);
  endtask

  task automatic a_send(input logic last);
    v[0] = 1'b1; l[0] = last;
    xr[0] = 19'($urandom); xi[0] = 19'($urandom);
    tick();
  endtask

  task automatic a_idle(input int n);
    v[0] = 1'b0; l[0] = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; xr[i] = '0; xi[i] = '0;
    end
    model_reset();
    #12;
    check_all(0);
    check_all(1);
    rst = 1'b1;

    // First burst: 16 priming samples, then 16 butterfly samples
    repeat (32) a_send(1'b0);
    // Second frame ends the burst; valid_i held high through FLUSH is ignored
    repeat (31) a_send(1'b0);
    a_send(1'b1);
    v[0] = 1'b1; l[0] = 1'b0;
    repeat (16) tick();
    a_idle(2);

    // New burst with a 3-cycle gap at cnt=20
    repeat (20) a_send(1'b0);
    a_idle(3);
    // Misplaced last at cnt=10 of the following block
    repeat (22) a_send(1'b0);
    a_send(1'b1);
    repeat (5) a_send(1'b0);

    // Random traffic on the STAGE=0 instance
    for (int n = 0; n < 150; n++) begin
      v[0]  = ($urandom_range(0, 3) != 0);
      l[0]  = ($urandom_range(0, 19) == 0);
      xr[0] = 19'($urandom);
      xi[0] = 19'($urandom);
      tick();
    end

    // Advance to cnt=25 in RUN, bounded
    for (int g = 0; g < 200 && !(fl[0] == 0 && s[0] >= 16 && s[0] % 32 == 25); g++)
      a_send(1'b0);
    chk("stg0.pre_reset_state", 32'(ifa.state), 32'(M_RUN));

    // Asynchronous reset mid-RUN
    v[0] = 1'b0; l[0] = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
    rst = 1'b1;

    // Restart primes again
    repeat (20) a_send(1'b0);
    a_idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
